// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, NOP constant and fetch FSM encoding
package mips_pkg;

  localparam int PC_W = 15;
  localparam int INSTR_W = 32;
  localparam int IMEM_DEPTH = 8192;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 15'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ifetch_imem.sv
// rtl/ifetch_imem.sv - instruction word array with per-word valid bits
module ifetch_imem
  import mips_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int IW = INSTR_W,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IDXW-1:0] waddr,
  input  logic [IW-1:0]   wdata,
  input  logic            re,
  input  logic [IDXW-1:0] raddr,
  output logic [IW-1:0]   rdata,
  output logic            rhit
);

  logic [IW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Contents survive reset on purpose so a loaded program can be rerun.
  always_ff @(posedge clk) begin
    if (we) begin
      data_q[waddr]  <= wdata;
      valid_q[waddr] <= 1'b1;
    end
    if (re) begin
      rdata <= data_q[raddr];
    end
  end

  // Valid lookup is combinational so the FSM can decide HALT on the same edge.
  assign rhit = valid_q[raddr];

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch FSM, PC register, ir mux and retire counter
module ifetch_unit
  import mips_pkg::*;
#(
  parameter int AW = PC_W,
  parameter int DEPTH = IMEM_DEPTH,
  parameter logic [AW-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP = NOP_INSTR,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [IDXW-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               stall,
  input  logic [AW-1:0]      npc,
  output logic [INSTR_W-1:0] ir,
  output logic [AW-1:0]      pc_cur,
  output logic               running,
  output logic               halted,
  output logic [31:0]        icount
);

  fetch_state_t       state;
  logic               active;
  logic               launch;
  logic               advance;
  logic               mem_we;
  logic               mem_re;
  logic [IDXW-1:0]    rd_idx;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_hit;
  logic               unused_npc_lsbs;

  assign active  = (state == S_RUN) || (state == S_STALL);
  assign launch  = (state == S_IDLE) && start && !prog_we;
  assign advance = active && !stall;
  assign mem_we  = !rst && prog_we && (state == S_IDLE);
  assign mem_re  = launch || advance;
  assign rd_idx  = (state == S_IDLE) ? RESET_PC[IDXW+1:2] : npc[IDXW+1:2];
  assign unused_npc_lsbs = ^npc[1:0];

  ifetch_imem #(.DEPTH(DEPTH), .IW(INSTR_W)) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (mem_re),
    .raddr (rd_idx),
    .rdata (mem_rdata),
    .rhit  (mem_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc_cur <= RESET_PC;
      icount <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            pc_cur <= RESET_PC;
            state  <= mem_hit ? S_RUN : S_HALT;
          end
        end
        S_RUN, S_STALL: begin
          if (stall) begin
            state <= S_STALL;
          end else begin
            pc_cur <= npc;
            icount <= icount + 32'd1;
            state  <= mem_hit ? S_RUN : S_HALT;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // The core only ever sees NOP outside RUN/STALL.
  assign ir      = active ? mem_rdata : NOP;
  assign running = active;
  assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [12:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [14:0] npc = '0;
  logic [31:0] ir;
  logic [14:0] pc_cur;
  logic        running;
  logic        halted;
  logic [31:0] icount;

  localparam logic [31:0] W_A = 32'h2008_0005;
  localparam logic [31:0] W_B = 32'h2009_0007;
  localparam logic [31:0] W_C = 32'h0109_5020;
  localparam logic [31:0] W_D = 32'hAC0A_0010;
  localparam logic [31:0] W_E = 32'h8C0B_0000;
  localparam logic [31:0] W_F = 32'h1111_2222;
  localparam logic [31:0] W_G = 32'h2010_0063;
  localparam logic [31:0] W_X = 32'hDEAD_BEEF;

  typedef struct {
    int          cyc;
    string       nm;
    logic [31:0] ir;
    logic [14:0] pc;
    logic        run;
    logic        halt;
    logic [31:0] ic;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  ifetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .stall     (stall),
    .npc       (npc),
    .ir        (ir),
    .pc_cur    (pc_cur),
    .running   (running),
    .halted    (halted),
    .icount    (icount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (ir === e.ir && pc_cur === e.pc && running === e.run &&
          halted === e.halt && icount === e.ic) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got ir=%h pc=%h run=%b halt=%b ic=%0d, want ir=%h pc=%h run=%b halt=%b ic=%0d",
                 e.nm, ir, pc_cur, running, halted, icount,
                 e.ir, e.pc, e.run, e.halt, e.ic);
      end
    end
  end

  // Push the expected state after the coming edge, then take that edge.
  task automatic tick(input string nm, input logic [31:0] eir, input logic [14:0] epc,
                      input logic erun, input logic ehalt, input logic [31:0] eic);
    exp_t e;
    e.cyc = cyc + 1; e.nm = nm; e.ir = eir; e.pc = epc;
    e.run = erun; e.halt = ehalt; e.ic = eic;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [12:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick("load_idle", 32'h0, 15'h0, 1'b0, 1'b0, 32'd0);
    prog_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick("reset", 32'h0, 15'h0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;

    load(13'd0, W_A); load(13'd1, W_B); load(13'd2, W_C);
    load(13'd4, W_D); load(13'd5, W_F); load(13'd64, W_E);

    // Straight-line run into an unloaded word.
    start = 1'b1;
    tick("start", W_A, 15'h0, 1'b1, 1'b0, 32'd0);
    start = 1'b0;
    npc = 15'h4;  tick("seq4",  W_B, 15'h4, 1'b1, 1'b0, 32'd1);
    npc = 15'h8;  tick("seq8",  W_C, 15'h8, 1'b1, 1'b0, 32'd2);
    npc = 15'hC;  tick("halt12", 32'h0, 15'hC, 1'b0, 1'b1, 32'd3);
    npc = 15'h0;  tick("halt_frozen", 32'h0, 15'hC, 1'b0, 1'b1, 32'd3);
    start = 1'b1; tick("halt_ignores_start", 32'h0, 15'hC, 1'b0, 1'b1, 32'd3);
    start = 1'b0;

    // Stall handling, ignored program write, jump, halt on jump target.
    rst = 1'b1; tick("reset2", 32'h0, 15'h0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    start = 1'b1; tick("start2", W_A, 15'h0, 1'b1, 1'b0, 32'd0);
    start = 1'b0;
    npc = 15'h10; stall = 1'b1;
    tick("stall1", W_A, 15'h0, 1'b1, 1'b0, 32'd0);
    tick("stall2", W_A, 15'h0, 1'b1, 1'b0, 32'd0);
    stall = 1'b0;
    tick("unstall", W_D, 15'h10, 1'b1, 1'b0, 32'd1);
    prog_we = 1'b1; prog_addr = 13'd5; prog_data = W_X; npc = 15'h14;
    tick("we_in_run", W_F, 15'h14, 1'b1, 1'b0, 32'd2);
    prog_we = 1'b0;
    npc = 15'h100; tick("jump64", W_E, 15'h100, 1'b1, 1'b0, 32'd3);
    npc = 15'h104; tick("jump65_halt", 32'h0, 15'h104, 1'b0, 1'b1, 32'd4);

    // Reset mid-run, rerun without reload, idx 5 still original.
    rst = 1'b1; tick("reset3", 32'h0, 15'h0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    start = 1'b1; tick("start3", W_A, 15'h0, 1'b1, 1'b0, 32'd0);
    start = 1'b0;
    npc = 15'h4; tick("run3_4", W_B, 15'h4, 1'b1, 1'b0, 32'd1);
    rst = 1'b1; npc = 15'h8;
    tick("reset_midrun", 32'h0, 15'h0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    start = 1'b1; tick("rerun", W_A, 15'h0, 1'b1, 1'b0, 32'd0);
    start = 1'b0;
    npc = 15'h15; tick("idx5_kept_lsb_ignored", W_F, 15'h15, 1'b1, 1'b0, 32'd1);

    // start coinciding with prog_we is ignored; the write still lands.
    rst = 1'b1; tick("reset4", 32'h0, 15'h0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    start = 1'b1; prog_we = 1'b1; prog_addr = 13'd0; prog_data = W_G;
    tick("start_with_we", 32'h0, 15'h0, 1'b0, 1'b0, 32'd0);
    prog_we = 1'b0;
    tick("start_after_we", W_G, 15'h0, 1'b1, 1'b0, 32'd0);
    start = 1'b0;
    npc = 15'h4; tick("new_prog_4", W_B, 15'h4, 1'b1, 1'b0, 32'd1);
    npc = 15'hC; tick("new_prog_halt", 32'h0, 15'hC, 1'b0, 1'b1, 32'd2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never compared, want 0", q.size());
      n_chk += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
